// File: rtl/pwm_ramp_sequencer_if.sv
// Duty-ramp bus: target/configuration from the register file in, ramped duty to the PWM out.
`timescale 1ns/1ps
interface pwm_ramp_sequencer_if;
    logic [7:0] target_duty;
    logic       target_valid;
    logic       ramp_en;
    logic [7:0] step_size;
    logic [7:0] rate_div;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;

    modport master (
        output target_duty, target_valid, ramp_en, step_size, rate_div,
        input  duty_out, busy, done
    );

    modport slave (
        input  target_duty, target_valid, ramp_en, step_size, rate_div,
        output duty_out, busy, done
    );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Walks the PWM duty toward the latest written target by a fixed step every
// (rate_div+1) << PRE_SHIFT cycles, or applies it at once in bypass mode.
`timescale 1ns/1ps
module pwm_ramp_sequencer #(
    parameter int         PRE_SHIFT  = 8,
    parameter logic [7:0] RESET_DUTY = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_ramp_sequencer_if.slave  bus
);
    localparam int CNT_W = 8 + PRE_SHIFT;

    typedef enum logic {IDLE, RAMP} state_t;

    state_t             state_q, state_d;
    logic [7:0]         duty_q, duty_d;
    logic [7:0]         target_q, target_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   term_cnt;
    logic [7:0]         step_eff;
    logic [8:0]         sum_up;
    logic signed [9:0]  diff_dn;
    logic [7:0]         stepped;

    // (rate_div+1) << PRE_SHIFT minus one, built without the extra carry bit.
    assign term_cnt = (CNT_W'(bus.rate_div) << PRE_SHIFT) | CNT_W'((1 << PRE_SHIFT) - 1);

    always_comb begin
        step_eff = (bus.step_size == 8'd0) ? 8'd1 : bus.step_size;
        sum_up   = {1'b0, duty_q} + {1'b0, step_eff};
        diff_dn  = $signed({2'b00, duty_q}) - $signed({2'b00, step_eff});
        if (duty_q < target_q)
            stepped = (sum_up >= {1'b0, target_q}) ? target_q : sum_up[7:0];
        else
            stepped = (diff_dn <= $signed({2'b00, target_q})) ? target_q : diff_dn[7:0];
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        cnt_d    = '0;
        done_d   = 1'b0;

        // A new target always wins over a pending step and restarts the interval.
        if (bus.target_valid) begin
            target_d = bus.target_duty;
            if (bus.target_duty == duty_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (!bus.ramp_en) begin
                duty_d  = bus.target_duty;
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RAMP;
            end
        end else if (state_q == RAMP) begin
            if (!bus.ramp_en) begin
                duty_d  = target_q;
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (cnt_q == term_cnt) begin
                duty_d = stepped;
                if (stepped == target_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            duty_q   <= RESET_DUTY;
            target_q <= RESET_DUTY;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign bus.duty_out = duty_q;
    assign bus.busy     = (state_q == RAMP);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: vector table, directed corner sequences,
// then randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pwm_ramp_sequencer;
    localparam int PRE_SHIFT = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_ramp_sequencer_if bus();

    pwm_ramp_sequencer #(.PRE_SHIFT(PRE_SHIFT), .RESET_DUTY(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] td;
        logic       tv;
        logic       re;
        logic [7:0] ss;
        logic [7:0] rd;
        logic [7:0] e_duty;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int m_duty, m_target, m_wait;
    bit m_ramping, m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] duty, input logic busy, input logic done);
        check({name, " duty"}, {24'd0, bus.duty_out}, {24'd0, duty});
        check({name, " busy"}, {31'd0, bus.busy}, {31'd0, busy});
        check({name, " done"}, {31'd0, bus.done}, {31'd0, done});
    endtask

    function automatic vec_t mk(logic [7:0] td, logic tv, logic re, logic [7:0] ss, logic [7:0] rd,
                                logic [7:0] e_duty, logic e_busy, logic e_done);
        vec_t v;
        v.td = td; v.tv = tv; v.re = re; v.ss = ss; v.rd = rd;
        v.e_duty = e_duty; v.e_busy = e_busy; v.e_done = e_done;
        return v;
    endfunction

    task automatic drive(input logic [7:0] td, input logic tv, input logic re,
                         input logic [7:0] ss, input logic [7:0] rd);
        bus.target_duty  = td;
        bus.target_valid = tv;
        bus.ramp_en      = re;
        bus.step_size    = ss;
        bus.rate_div     = rd;
    endtask

    task automatic model_reset();
        m_duty = 0; m_target = 0; m_wait = 0; m_ramping = 0; m_done = 0;
    endtask

    // Behavioural rules: a strobe retargets, otherwise a ramp advances one step per interval.
    task automatic model_step();
        int s, interval;
        m_done = 0;
        if (bus.target_valid) begin
            m_target = int'(bus.target_duty);
            m_wait   = 0;
            if (m_target == m_duty) begin
                m_ramping = 0; m_done = 1;
            end else if (!bus.ramp_en) begin
                m_duty = m_target; m_ramping = 0; m_done = 1;
            end else begin
                m_ramping = 1;
            end
        end else if (m_ramping) begin
            if (!bus.ramp_en) begin
                m_duty = m_target; m_ramping = 0; m_done = 1;
            end else begin
                m_wait++;
                interval = (int'(bus.rate_div) + 1) << PRE_SHIFT;
                if (m_wait == interval) begin
                    m_wait = 0;
                    s = (bus.step_size == 0) ? 1 : int'(bus.step_size);
                    if (m_duty < m_target) m_duty = (m_duty + s > m_target) ? m_target : m_duty + s;
                    else                   m_duty = (m_duty - s < m_target) ? m_target : m_duty - s;
                    if (m_duty == m_target) begin
                        m_ramping = 0; m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(8'h00, 1'b0, 1'b1, 8'h10, 8'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int dones;
        drive(8'h00, 1'b0, 1'b1, 8'h10, 8'd0);
        rst_n = 1'b0;
        #1;
        check_out("reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: basic ramp, bypass, equal-target strobe.
        vecs.push_back(mk(8'h40, 1, 1, 8'h10, 8'd3, 8'h00, 1, 0));
        for (int k = 1; k <= 17; k++)
            vecs.push_back(mk(8'h40, 0, 1, 8'h10, 8'd3,
                              (k >= 16) ? 8'h40 : 8'(16 * (k / 4)), k < 16, k == 16));
        vecs.push_back(mk(8'h7F, 1, 0, 8'h10, 8'd3, 8'h7F, 0, 1));
        vecs.push_back(mk(8'h7F, 0, 0, 8'h10, 8'd3, 8'h7F, 0, 0));
        vecs.push_back(mk(8'h7F, 1, 1, 8'h10, 8'd3, 8'h7F, 0, 1));
        vecs.push_back(mk(8'h7F, 0, 1, 8'h10, 8'd3, 8'h7F, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].td, vecs[i].tv, vecs[i].re, vecs[i].ss, vecs[i].rd);
            tick();
            check_out($sformatf("vec[%0d]", i), vecs[i].e_duty, vecs[i].e_busy, vecs[i].e_done);
        end

        // Step down with no underflow: F0 -> A0, 50, 00.
        drive(8'hF0, 1, 0, 8'h50, 8'd0); tick();
        drive(8'h00, 1, 1, 8'h50, 8'd0); tick();
        check_out("down strobe", 8'hF0, 1, 0);
        drive(8'h00, 0, 1, 8'h50, 8'd0);
        tick(); check_out("down 1", 8'hA0, 1, 0);
        tick(); check_out("down 2", 8'h50, 1, 0);
        tick(); check_out("down 3", 8'h00, 0, 1);
        tick(); check_out("down after", 8'h00, 0, 0);

        // Step up with no wrap: F0 -> FF in one step.
        drive(8'hF0, 1, 0, 8'h20, 8'd0); tick();
        drive(8'hFF, 1, 1, 8'h20, 8'd0); tick();
        check_out("up strobe", 8'hF0, 1, 0);
        drive(8'hFF, 0, 1, 8'h20, 8'd0);
        tick(); check_out("up clamp", 8'hFF, 0, 1);

        // Mid-ramp retarget at 0x30 toward 0x10.
        do_reset();
        dones = 0;
        drive(8'h80, 1, 1, 8'h10, 8'd1); tick(); dones += bus.done;
        drive(8'h80, 0, 1, 8'h10, 8'd1);
        repeat (6) begin tick(); dones += bus.done; end
        check_out("retarget pre", 8'h30, 1, 0);
        drive(8'h10, 1, 1, 8'h10, 8'd1); tick(); dones += bus.done;
        check_out("retarget edge", 8'h30, 1, 0);
        drive(8'h10, 0, 1, 8'h10, 8'd1);
        tick(); dones += bus.done; check_out("retarget +1", 8'h30, 1, 0);
        tick(); dones += bus.done; check_out("retarget +2", 8'h20, 1, 0);
        tick(); dones += bus.done;
        tick(); dones += bus.done; check_out("retarget +4", 8'h10, 0, 1);
        tick(); dones += bus.done;
        check("retarget done count", 32'(dones), 32'd1);

        // Asynchronous reset mid-ramp.
        do_reset();
        drive(8'h80, 1, 1, 8'h10, 8'd1); tick();
        drive(8'h80, 0, 1, 8'h10, 8'd1);
        repeat (6) tick();
        check_out("pre reset", 8'h30, 1, 0);
        #2 rst_n = 1'b0;
        #1 check_out("async reset", 8'h00, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        check_out("post reset idle", 8'h00, 0, 0);

        // step_size 0 behaves as 1.
        drive(8'h03, 1, 1, 8'h00, 8'd0); tick();
        check_out("step0 strobe", 8'h00, 1, 0);
        drive(8'h03, 0, 1, 8'h00, 8'd0);
        tick(); check_out("step0 1", 8'h01, 1, 0);
        tick(); check_out("step0 2", 8'h02, 1, 0);
        tick(); check_out("step0 3", 8'h03, 0, 1);

        // Strobe on a step edge suppresses the step and restarts the interval.
        do_reset();
        drive(8'h80, 1, 1, 8'h10, 8'd1); tick();
        drive(8'h80, 0, 1, 8'h10, 8'd1); tick();
        drive(8'h80, 1, 1, 8'h10, 8'd1); tick();
        check_out("coincide edge", 8'h00, 1, 0);
        drive(8'h80, 0, 1, 8'h10, 8'd1);
        tick(); check_out("coincide +1", 8'h00, 1, 0);
        tick(); check_out("coincide +2", 8'h10, 1, 0);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic tv;
            tv = ($urandom_range(0, 15) == 0);
            bus.target_valid = tv;
            bus.ramp_en      = ($urandom_range(0, 19) != 0);
            bus.step_size    = 8'($urandom);
            if (tv) begin
                bus.target_duty = 8'($urandom);
                bus.rate_div    = 8'($urandom_range(0, 3));
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("rand duty", {24'd0, bus.duty_out}, 32'(m_duty));
            check("rand busy", {31'd0, bus.busy}, {31'd0, m_ramping});
            check("rand done", {31'd0, bus.done}, {31'd0, m_done});
            check("rand busy&done", {31'd0, bus.busy & bus.done}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
Sequences updates to the PWM duty-cycle register so that duty changes ramp gradually instead of stepping instantly (soft-start/fade).
Sits between the SPI register file's duty-cycle byte and the PWM peripheral's duty input.
Latches a new target on each duty-register write, then walks duty_out toward that target by a fixed step every programmable interval.
Supports a bypass mode that applies the target immediately.

Parameters:
PRE_SHIFT, 8, left shift applied to the step interval; interval = (rate_div+1) << PRE_SHIFT clk cycles
RESET_DUTY, 8'h00, value of duty_out and the internal target after reset

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
target_duty  input  8  requested duty cycle from the SPI register file
target_valid  input  1  one-cycle strobe: target_duty was written this cycle
ramp_en  input  1  1 = ramp toward target; 0 = bypass (apply target directly)
step_size  input  8  duty increment per step; 0 is treated as 1
rate_div  input  8  interval divider; see PRE_SHIFT
duty_out  output  8  duty cycle driven to the PWM peripheral
busy  output  1  high while duty_out != latched target
done  output  1  one-cycle pulse when duty_out reaches target

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All state is clocked on the rising edge of clk.
- Reset values: duty_out=RESET_DUTY, target register=RESET_DUTY, busy=0, done=0, interval counter=0, state=IDLE.
- Reset may be asserted at any time, including mid-ramp. Outputs take their reset values immediately, with no clock required.
- States: IDLE, RAMP.
- IDLE behaviour:
  - target_valid is sampled on edge N; the target register loads target_duty on that edge.
  - If target_duty == duty_out: stay IDLE; done=1 for the cycle after edge N; busy stays 0.
  - Else if ramp_en=0: duty_out=target_duty from edge N; done=1 for one cycle; stay IDLE.
  - Else: go to RAMP; busy=1 from edge N; interval counter cleared.
- RAMP behaviour:
  - The counter increments each clk.
  - When counter == ((rate_div+1) << PRE_SHIFT) - 1, the counter wraps to 0 and one step is applied.
  - Step up (duty < target): duty = min(duty + s, target), computed 9-bit with no wrap.
  - Step down: duty = max(duty - s, target), computed 9-bit signed with no underflow.
  - s = step_size, or 1 if step_size == 0.
  - On the edge where duty_out becomes equal to target: go to IDLE; busy=0 and done=1 in the following cycle (one cycle only).
- rate_div and step_size are sampled at each step, not latched. A change takes effect at the next comparison.
- target_valid during RAMP:
  - The target register reloads and the counter restarts at 0.
  - The ramp continues from the current duty_out toward the new target; direction is re-evaluated.
  - If the new target equals duty_out: IDLE, busy=0, done pulse.
- ramp_en falling during RAMP: on the next edge duty_out=target, state IDLE, done pulse.
- Simultaneous target_valid and step-point on the same edge: target_valid wins; no step is applied that edge.
- done and busy are never high in the same cycle.
- duty_out changes only on a step, in bypass, or at reset. It is glitch-free (registered).

Test Plan:
- PRE_SHIFT=0, rate_div=3, step=0x10, ramp_en=1; reset, then target 0x40 -> duty_out steps 0x10, 0x20, 0x30, 0x40 at 4, 8, 12, 16 cycles after the strobe edge; busy high through that; done single pulse after 0x40; busy=0.
- From 0xF0, target 0x00, step 0x50, rate_div=0 -> 0xA0, 0x50, 0x00 on consecutive cycles. From 0xF0, target 0xFF, step 0x20 -> single step to 0xFF, no wrap to 0x10.
- ramp_en=0, target 0x7F -> duty_out=0x7F one cycle after the strobe; busy never high; done one pulse. Target equal to current duty -> done pulse only, duty_out unchanged.
- Mid-ramp retarget: ramping 0x00->0x80 (step 0x10, rate_div=1) at duty_out=0x30, strobe target 0x10 -> counter restarts; duty_out goes 0x20, then 0x10; one done pulse total.
- Reset mid-ramp (duty_out=0x30) with RESET_DUTY=0 -> duty_out=0x00, busy=0, done=0 immediately without a clock edge; after release stays IDLE until the next strobe.
- step_size=0, rate_div=0, 0x00->0x03 -> 0x01, 0x02, 0x03 on consecutive cycles. Strobe coinciding with a step edge -> no step that edge, counter restarts.
